nand_2_9: RTL and testbench

- Parameterised bitwise 2-input NAND over WIDTH-bit vectors.
- Primary output is purely combinational; a registered copy with a valid strobe is also provided for pipelined consumers.
- Leaf datapath block used wherever a wide inverted-AND mask is needed; no handshake back-pressure.

---
 rtl/nand_2_9.sv | 73 +++++++
 tb/tb_nand_2_9.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nand_2_9.sv
// Bitwise 2-input NAND over WIDTH-bit operands, with a combinational result and a registered copy.
// Optional transaction/zero-result counters are enabled by defining NAND_2_9_STATS_EN.
module nand_2_9 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_data_r,
    output logic             out_valid
`ifdef NAND_2_9_STATS_EN
    ,
    output logic [15:0]      txn_count,
    output logic [15:0]      zero_count
`endif
);

    logic [WIDTH-1:0] w_nand;
    logic             w_zero;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_comb begin
        w_nand = ~(in_data1 & in_data2);
        w_zero = ~|w_nand;
    end

    assign out_data   = w_nand;
    assign out_zero   = w_zero;
    assign out_data_r = r_data;
    assign out_valid  = r_valid;

    // Reset value is the NAND of all-zero operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= {WIDTH{1'b1}};
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= w_nand;
            end
        end
    end

`ifdef NAND_2_9_STATS_EN
    logic [15:0] r_txn_count;
    logic [15:0] r_zero_count;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_count  <= 16'd0;
            r_zero_count <= 16'd0;
        end else if (in_valid) begin
            if (r_txn_count != 16'hFFFF) begin
                r_txn_count <= r_txn_count + 16'd1;
            end
            if (w_zero && (r_zero_count != 16'hFFFF)) begin
                r_zero_count <= r_zero_count + 16'd1;
            end
        end
    end

    assign txn_count  = r_txn_count;
    assign zero_count = r_zero_count;
`endif

endmodule

// File: tb/tb_nand_2_9.sv
// Scoreboard bench for nand_2_9: driver pushes expected registered results, monitor pops on out_valid.
// Counter checks run only when NAND_2_9_STATS_EN is defined.
module tb_nand_2_9;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data1;
    logic [W-1:0] in_data2;
    logic         in_valid;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic [W-1:0] out_data_r;
    logic         out_valid;
`ifdef NAND_2_9_STATS_EN
    logic [15:0]  txn_count;
    logic [15:0]  zero_count;
`endif

    nand_2_9 #(
        .WIDTH(W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_data_r(out_data_r),
        .out_valid (out_valid)
`ifdef NAND_2_9_STATS_EN
        ,
        .txn_count (txn_count),
        .zero_count(zero_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] q_exp[$];
    logic [W-1:0] exp_r;
    int           m_txn;
    int           m_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         v;
        logic [W-1:0] e;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: apply at negedge, check combinational outputs, record acceptance.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v,
                         input logic [W-1:0] e);
        @(negedge clk);
        in_data1 = a;
        in_data2 = b;
        in_valid = v;
        #1;
        check("comb_data", out_data, e);
        check("comb_zero", out_zero, e == '0);
        @(posedge clk);
        if (rst_n && v) begin
            q_exp.push_back(e);
            exp_r = e;
            if (m_txn < 16'hFFFF) m_txn++;
            if (e == '0 && m_zero < 16'hFFFF) m_zero++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_r    = '1;
        m_txn    = 0;
        m_zero   = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples just after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (out_valid === 1'b1) begin
                if (q_exp.size() == 0) begin
                    check("spurious_valid", out_valid, 1'b0);
                end else begin
                    check("reg_data", out_data_r, q_exp.pop_front());
                end
            end else begin
                check("reg_valid_known", out_valid, 1'b0);
                check("reg_hold", out_data_r, exp_r);
            end
        end
    end

    vec_t dir[8] = '{
        '{4'hC, 4'hA, 1'b1, 4'h7},
        '{4'h0, 4'h0, 1'b0, 4'hF},
        '{4'h3, 4'h1, 1'b1, 4'hE},
        '{4'hF, 4'hF, 1'b1, 4'h0},
        '{4'hF, 4'hE, 1'b1, 4'h1},
        '{4'h5, 4'hA, 1'b0, 4'hF},
        '{4'h9, 4'h6, 1'b1, 4'hF},
        '{4'h8, 4'hC, 1'b1, 4'h7}
    };

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n    = 1'b0;
        in_data1 = '0;
        in_data2 = '0;
        in_valid = 1'b0;
        exp_r    = '1;
        m_txn    = 0;
        m_zero   = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_data_r", out_data_r, 4'hF);
        check("rst_valid", out_valid, 1'b0);
        check("rst_comb", out_data, 4'hF);
        check("rst_zero", out_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir[i]) drive(dir[i].a, dir[i].b, dir[i].v, dir[i].e);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = i[W-1:0];
                b = j[W-1:0];
                drive(a, b, ((i + j) % 3) != 0, ~(a & b));
            end
        end

        // Async reset between edges with a transaction in flight.
        drive(4'h5, 4'h3, 1'b1, 4'hE);
        @(negedge clk);
        in_data1 = 4'h6;
        in_data2 = 4'h9;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        exp_r = '1;
        #1;
        check("async_rst_data_r", out_data_r, 4'hF);
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_comb", out_data, 4'hF);
        in_data1 = 4'hB;
        in_data2 = 4'hE;
        #1;
        check("async_rst_comb2", out_data, 4'h5);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        m_txn    = 0;
        m_zero   = 0;
        rst_n    = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 4'hF);

        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            drive(a, b, $urandom_range(0, 1) == 1, ~(a & b));
        end

        // Counter phase: 5 accepted transactions, 2 with all-ones operands.
        do_reset();
        drive(4'hF, 4'hF, 1'b1, 4'h0);
        drive(4'h1, 4'h2, 1'b1, 4'hF);
        drive(4'hF, 4'hF, 1'b0, 4'h0);
        drive(4'hF, 4'hF, 1'b1, 4'h0);
        drive(4'h7, 4'hF, 1'b1, 4'h8);
        drive(4'hA, 4'hA, 1'b1, 4'h5);
        drive(4'h0, 4'h0, 1'b0, 4'hF);
`ifdef NAND_2_9_STATS_EN
        #1;
        check("txn_count", txn_count, 16'd5);
        check("zero_count", zero_count, 16'd2);
        check("txn_model", txn_count, m_txn);
        do_reset();
        #1;
        check("txn_count_rst", txn_count, 16'd0);
        check("zero_count_rst", zero_count, 16'd0);
`endif

        @(posedge clk);
        #3;
        check("queue_drained", q_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
